// File: rtl/bram_uart_dump.sv
// rtl/bram_uart_dump.sv - streams a range of BRAM words out over UART 8N1, byte 0 of each word first
module bram_uart_dump #(
    parameter int DEPTH        = 16384,
    parameter int WIDTH        = 64,
    parameter int READ_LATENCY = 2,
    parameter int BAUD_DIV     = 868,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [ADDR_W:0]   count_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_re_out,
    input  logic [WIDTH-1:0]  bram_data_in,
    output logic              tx_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int NBYTES  = WIDTH / 8;
    localparam int BAUD_W  = $clog2(BAUD_DIV);
    localparam int FETCH_W = $clog2(READ_LATENCY + 1);
    localparam int BYTE_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(READ_LATENCY - 1);
    localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]    ONE_WORD   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [FETCH_W-1:0] fetch_cnt;
    logic [3:0]         bit_cnt;
    logic [BYTE_W-1:0]  byte_cnt;
    logic [ADDR_W:0]    words_left;
    logic [WIDTH-1:0]   shreg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            bram_addr_out <= '0;
            bram_re_out   <= 1'b0;
            tx_out        <= 1'b1;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            baud_cnt      <= '0;
            fetch_cnt     <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            words_left    <= '0;
            shreg         <= '0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (start_in) begin
                        if (count_in == '0) begin
                            done_out <= 1'b1;
                        end else begin
                            bram_addr_out <= base_addr_in;
                            words_left    <= count_in;
                            bram_re_out   <= 1'b1;
                            busy_out      <= 1'b1;
                            fetch_cnt     <= '0;
                            state         <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fetch_cnt == FETCH_LAST) begin
                        bram_re_out <= 1'b0;
                        state       <= LOAD;
                    end else begin
                        fetch_cnt <= fetch_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    // dout is valid this cycle; the start bit goes out on the same edge
                    shreg    <= bram_data_in;
                    tx_out   <= 1'b0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    state    <= START;
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx_out   <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_cnt  <= 4'd1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd8) begin
                            tx_out  <= 1'b1;
                            bit_cnt <= 4'd9;
                            state   <= STOP;
                        end else begin
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (byte_cnt != BYTE_LAST) begin
                            // the shift register already holds the next byte in its low bits
                            byte_cnt <= byte_cnt + 1'b1;
                            bit_cnt  <= '0;
                            tx_out   <= 1'b0;
                            state    <= START;
                        end else if (words_left == ONE_WORD) begin
                            busy_out <= 1'b0;
                            done_out <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            words_left    <= words_left - ONE_WORD;
                            bram_addr_out <= (bram_addr_out == ADDR_LAST) ? '0
                                                                          : bram_addr_out + 1'b1;
                            bram_re_out   <= 1'b1;
                            fetch_cnt     <= '0;
                            state         <= FETCH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
